// File: rtl/serial_deserializer.sv
// ---------------------------------------------------------------------------
// serial_deserializer
//
// Serial-in / parallel-out receiver. It rebuilds WIDTH-bit words from the bit
// stream that the universal shift register produces in its shift modes.
// Each word can be framed MSB-first or LSB-first. Completed words are held in
// a one-word output buffer that uses a valid/ready handshake. If a word
// completes while the buffer is still occupied, the new word is dropped and
// the sticky overrun flag is set.
//
// Optional feature (macro SERIAL_DESER_PARITY_CHECK_EN):
//   When the macro is defined, each word is followed by one even-parity bit.
//   p_perr is the XOR of the data bits and the parity bit, and it travels with
//   the word. When the macro is undefined, p_perr is tied to 0.
//
// Parameters:
//   WIDTH  data word width in bits (>= 2)
//   CNT_W  bit-counter width, 2**CNT_W > WIDTH
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   s_valid      serial bit present on s_din this cycle
//   s_din        serial data bit
//   s_sof        start of frame, marks bit 1 of a word (qualified by s_valid)
//   s_dir        0 = MSB-first, 1 = LSB-first (sampled with the sof bit)
//   p_dout       assembled word, meaningful while p_valid = 1
//   p_valid      output buffer holds an unconsumed word
//   p_ready      downstream accepts p_dout when p_valid & p_ready
//   p_perr       parity error flag for the word on p_dout
//   overrun      sticky flag, a completed word was dropped
//   clr_overrun  synchronous clear of overrun
// ---------------------------------------------------------------------------
module serial_deserializer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic             s_din,
  input  logic             s_sof,
  input  logic             s_dir,
  output logic [WIDTH-1:0] p_dout,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             p_perr,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef SERIAL_DESER_PARITY_CHECK_EN
  localparam logic [1:0] PAR   = 2'd2;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic             dir, dir_nx;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] sof_load;
  logic             done;
  logic [WIDTH-1:0] done_word;
`ifdef SERIAL_DESER_PARITY_CHECK_EN
  logic             done_perr;
  logic             perr_q;
`endif

  // The sof bit starts from a cleared register. Any stale partial word is
  // dropped immediately, so a resync never mixes bits from two frames.
  assign shifted  = dir   ? {s_din, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], s_din};
  assign sof_load = s_dir ? {s_din, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, s_din};

  // Next-state logic. A sof bit restarts framing from any state. Bits that
  // arrive without sof in IDLE are ignored.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    shreg_nx  = shreg;
    dir_nx    = dir;
    done      = 1'b0;
    done_word = shifted;
`ifdef SERIAL_DESER_PARITY_CHECK_EN
    done_perr = 1'b0;
`endif
    if (s_valid) begin
      if (s_sof) begin
        state_nx = SHIFT;
        cnt_nx   = CNT_W'(1);
        shreg_nx = sof_load;
        dir_nx   = s_dir;
      end else begin
        case (state)
          SHIFT: begin
            shreg_nx = shifted;
            cnt_nx   = cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              cnt_nx = '0;
`ifdef SERIAL_DESER_PARITY_CHECK_EN
              state_nx = PAR;
`else
              state_nx = IDLE;
              done     = 1'b1;
`endif
            end
          end
`ifdef SERIAL_DESER_PARITY_CHECK_EN
          // The data word is already complete in shreg. The current bit is the
          // parity bit, and it is not shifted in.
          PAR: begin
            state_nx  = IDLE;
            done      = 1'b1;
            done_word = shreg;
            done_perr = ^{shreg, s_din};
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Framing registers, output buffer and sticky overrun flag. A completing
  // word can be loaded only if the buffer is empty or is being drained in the
  // same cycle. Otherwise the old word stays in place and the new one is lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      dir     <= 1'b0;
      p_dout  <= '0;
      p_valid <= 1'b0;
      overrun <= 1'b0;
`ifdef SERIAL_DESER_PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      shreg <= shreg_nx;
      dir   <= dir_nx;

      if (done && (!p_valid || p_ready)) begin
        p_dout  <= done_word;
        p_valid <= 1'b1;
`ifdef SERIAL_DESER_PARITY_CHECK_EN
        perr_q  <= done_perr;
`endif
      end else if (p_valid && p_ready) begin
        p_valid <= 1'b0;
      end

      if (done && p_valid && !p_ready) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef SERIAL_DESER_PARITY_CHECK_EN
  assign p_perr = perr_q;
`else
  assign p_perr = 1'b0;
`endif

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Serial-in/parallel-out receiver. It accepts the bit stream that the universal shift register emits in its shift modes and rebuilds WIDTH-bit words.
- Supports MSB-first (shift-left) and LSB-first (shift-right) framing, selected per word.
- Completed words sit in a one-word output buffer with a valid/ready handshake toward downstream logic.
- Overrun, when the buffer is still occupied, is detected and flagged sticky.

Parameters:
- WIDTH, 4, data word width in bits (≥2); matches the shift register's parallel width.
- CNT_W, 3, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock, single domain.
- rst  input  1  synchronous active-low reset; rst=0 at a rising edge resets the block.
- s_valid  input  1  serial bit present on s_din this cycle.
- s_din  input  1  serial data bit.
- s_sof  input  1  start-of-frame; qualified by s_valid; marks the first bit of a word.
- s_dir  input  1  0 = MSB-first (shift-left), 1 = LSB-first (shift-right); sampled with the sof bit.
- p_dout  output  WIDTH  assembled word; valid while p_valid=1.
- p_valid  output  1  output buffer holds an unconsumed word.
- p_ready  input  1  downstream accepts p_dout when p_valid & p_ready.
- p_perr  output  1  parity error for the word on p_dout (see Optional Feature).
- overrun  output  1  sticky: a completed word was dropped.
- clr_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rst=0 at edge):
  - p_dout=0, p_valid=0, p_perr=0, overrun=0.
  - Shift register=0, bit counter=0, FSM=IDLE.
  - Any partial word is discarded.
  - Reset wins over every other input.
- No backpressure on the serial side: every s_valid bit is consumed in the cycle it arrives. s_valid=0 cycles are gaps; state holds.
- FSM states: IDLE, SHIFT, PAR (PAR exists only with the macro).
  - IDLE: bits without s_sof are ignored. On s_valid&s_sof: capture s_dir into the word direction, shift in the bit, counter=1, go to SHIFT.
  - SHIFT: on each s_valid, shift in the bit and increment the counter.
  - On the WIDTH-th bit, go to PAR (macro on) or complete the word and return to IDLE.
  - s_valid&s_sof in SHIFT or PAR is a resync: discard the partial word and restart as from IDLE with this bit as bit 1. No flag is raised.
- Shift rules (dir latched per word):
  - dir=0: reg <= {reg[WIDTH-2:0], din}. The first bit lands at the MSB.
  - dir=1: reg <= {din, reg[WIDTH-1:1]}. The first bit lands at bit 0.
- Completion: the final bit is accepted at edge N. p_dout is loaded and p_valid=1 after edge N, so output latency is 1 cycle from the last bit.
- Handshake:
  - p_valid&p_ready at an edge consumes the word; p_valid falls unless a new word completes at the same edge.
  - p_dout/p_valid hold stable while p_valid=1 and p_ready=0.
- Simultaneous events:
  - Completion with p_valid=0: load the word.
  - Completion with p_valid=1 and p_ready=1: consume the old word and load the new one; p_valid stays 1.
  - Completion with p_valid=1 and p_ready=0: the new word is dropped, the old word is retained, overrun is set.
  - Set and clr_overrun in the same cycle: set wins.
- Back-to-back words are supported: a sof bit may arrive in the cycle right after the last bit. Sustained throughput is one word per WIDTH bits.

Optional Feature:
- Macro: SERIAL_DESER_PARITY_CHECK_EN.
- Defined:
  - One extra parity bit follows the WIDTH data bits; state PAR consumes it.
  - Even parity: p_perr = XOR(data bits, parity bit). p_perr is loaded with p_dout and follows the same hold/consume rules.
  - Completion occurs on the parity bit; the word is delivered even on an error.
- Undefined:
  - PAR state absent; the word completes on the WIDTH-th data bit.
  - p_perr is constant 0.

Test Plan:
- Reset/idle:
  - Hold rst=0 for 2 cycles while s_valid toggles: all outputs 0.
  - Release and drive bits without s_sof: p_valid stays 0.
- MSB-first:
  - dir=0, sof on first bit, stream 1,0,1,0 on consecutive cycles: one cycle after the 4th bit, p_dout=4'hA, p_valid=1.
  - p_ready=1 one cycle later: p_valid=0.
- LSB-first with gaps:
  - dir=1, bits 1,0,1,1 with s_valid=0 gaps between them: p_dout=4'hD.
  - p_valid asserts only after the 4th valid bit.
- Back-to-back and overrun:
  - Word 4'h5 then word 4'h3 immediately (dir=0) with p_ready=0: p_dout stays 4'h5, overrun=1 after the 2nd word's last bit.
  - clr_overrun: overrun=0.
  - Repeat with p_ready=1 at completion: p_dout=4'h3, p_valid held 1, no overrun.
- Resync and reset mid-word:
  - sof mid-word after 2 bits, then 4 bits 1,1,0,0 (dir=0): p_dout=4'hC.
  - rst=0 after 3 bits, then a full word 4'h9: p_dout=4'h9, no stale bits.
- Parity (macro on):
  - 4'hA plus parity bit 0: p_perr=0.
  - 4'hA plus parity bit 1: p_perr=1, p_dout=4'hA delivered.
